// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC accumulate unit: FSM states,
// default widths and the saturation limits used when MAC_SATURATE_EN is defined.
package mac_pkg;

    localparam int unsigned MAC_DATA_W = 32;
    localparam int unsigned MAC_ACC_W  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULT  = 2'd1,
        ACCUM = 2'd2
    } mac_state_e;

    localparam logic [MAC_ACC_W-1:0] SAT_POS_MAX = {1'b0, {(MAC_ACC_W-1){1'b1}}};
    localparam logic [MAC_ACC_W-1:0] SAT_NEG_MIN = {1'b1, {(MAC_ACC_W-1){1'b0}}};
    localparam logic [MAC_ACC_W-1:0] SAT_U_MAX   = {MAC_ACC_W{1'b1}};

endpackage

// File: rtl/mac_accumulate_unit_if.sv
// Operand/result bundle between the MAC operand register (master) and the
// accumulate unit (slave).
interface mac_accumulate_unit_if
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = MAC_DATA_W,
    parameter int unsigned ACC_W  = MAC_ACC_W
);

    logic [2*DATA_W-1:0] mor_in;
    logic                start;
    logic                signed_mode;
    logic                clear_acc;
    logic                busy;
    logic                done;
    logic [ACC_W-1:0]    acc_out;
    logic                overflow;

    modport master (
        output mor_in, start, signed_mode, clear_acc,
        input  busy, done, acc_out, overflow
    );

    modport slave (
        input  mor_in, start, signed_mode, clear_acc,
        output busy, done, acc_out, overflow
    );

endinterface

// File: rtl/mac_shift_add_multiplier.sv
// Unsigned sequential shift-add multiplier, one multiplier bit per step.
// last is high while the final (DATA_W-th) step is being taken.
module mac_shift_add_multiplier
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = MAC_DATA_W,
    parameter int unsigned ACC_W  = MAC_ACC_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [ACC_W-1:0]  product,
    output logic              last
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic [ACC_W-1:0]  mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [ACC_W-1:0]  partial_q, partial_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        partial_d = partial_q;
        count_d   = count_q;
        if (load) begin
            mcand_d   = {{(ACC_W-DATA_W){1'b0}}, a_in};
            mplier_d  = b_in;
            partial_d = '0;
            count_d   = '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                partial_d = partial_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            partial_q <= '0;
            count_q   <= '0;
        end else begin
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            partial_q <= partial_d;
            count_q   <= count_d;
        end
    end

    assign product = partial_q;
    assign last    = (count_q == LAST_CNT);

endmodule

// File: rtl/mac_accumulate_unit.sv
// Multiply-accumulate unit: sequential multiply of the packed operand pair,
// then add into a 64-bit accumulator with a sticky overflow flag.
// Optional build macro: MAC_SATURATE_EN (clamp acc_out on overflow).
module mac_accumulate_unit
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W = MAC_DATA_W,
    parameter int unsigned ACC_W  = MAC_ACC_W
) (
    input  logic                  clock,
    input  logic                  reset,
    mac_accumulate_unit_if.slave  bus
);

    mac_state_e       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             neg_q, neg_d;
    logic             sm_q, sm_d;

    logic [DATA_W-1:0] op_a, op_b, mag_a, mag_b;
    logic              mul_load, mul_step, mul_last;
    logic [ACC_W-1:0]  partial, product;
    logic [ACC_W:0]    sum;
    logic              ovf_now;

    assign op_a = bus.mor_in[DATA_W-1:0];
    assign op_b = bus.mor_in[2*DATA_W-1:DATA_W];

    // Signed operands are multiplied as magnitudes; -2^(DATA_W-1) maps to itself,
    // which is the correct unsigned magnitude.
    always_comb begin
        mag_a = (bus.signed_mode && op_a[DATA_W-1]) ? -op_a : op_a;
        mag_b = (bus.signed_mode && op_b[DATA_W-1]) ? -op_b : op_b;
    end

    mac_shift_add_multiplier #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mult (
        .clock   (clock),
        .reset   (reset),
        .load    (mul_load),
        .step    (mul_step),
        .a_in    (mag_a),
        .b_in    (mag_b),
        .product (partial),
        .last    (mul_last)
    );

    always_comb begin
        product = neg_q ? -partial : partial;
        sum     = {1'b0, acc_q} + {1'b0, product};
        if (sm_q) begin
            ovf_now = (acc_q[ACC_W-1] == product[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_q[ACC_W-1]);
        end else begin
            ovf_now = sum[ACC_W];
        end
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        sm_d     = sm_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear_acc) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end
                if (bus.start) begin
                    mul_load = 1'b1;
                    sm_d     = bus.signed_mode;
                    neg_d    = bus.signed_mode & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
                    busy_d   = 1'b1;
                    state_d  = MULT;
                end
            end
            MULT: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
`ifdef MAC_SATURATE_EN
                if (ovf_now) begin
                    acc_d = sm_q ? (acc_q[ACC_W-1] ? SAT_NEG_MIN : SAT_POS_MAX) : SAT_U_MAX;
                end else begin
                    acc_d = sum[ACC_W-1:0];
                end
`else
                acc_d = sum[ACC_W-1:0];
`endif
                ovf_d   = ovf_q | ovf_now;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            sm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            neg_q   <= neg_d;
            sm_q    <= sm_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.acc_out  = acc_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_mac_accumulate_unit.sv
// Directed bench for mac_accumulate_unit: latency, accumulate, signed,
// start-while-busy, clear_acc and overflow/saturation behaviour.
module tb_mac_accumulate_unit;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mac_accumulate_unit_if #(.DATA_W(32), .ACC_W(64)) bus ();

    mac_accumulate_unit #(.DATA_W(32), .ACC_W(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.clear_acc   = 1'b0;
        bus.mor_in      = '0;
    endtask

    task automatic do_clear();
        @(negedge clock);
        bus.clear_acc = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        bus.clear_acc = 1'b0;
    endtask

    // Issues one operation and waits (bounded) for done; lat counts edges after the start edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sm,
                          input logic clr, output int lat, output logic [63:0] res,
                          output logic busy_after_start, output logic done_after_start);
        @(negedge clock);
        bus.mor_in      = {b, a};
        bus.start       = 1'b1;
        bus.signed_mode = sm;
        bus.clear_acc   = clr;
        @(posedge clock);
        #1;
        busy_after_start = bus.busy;
        done_after_start = bus.done;
        @(negedge clock);
        bus.start     = 1'b0;
        bus.clear_acc = 1'b0;
        bus.mor_in    = 64'hDEAD_BEEF_0BAD_F00D;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(posedge clock);
            #1;
            lat++;
        end
        res = bus.acc_out;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.overflow} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/ovf=%b required 000", {bus.busy, bus.done, bus.overflow});
        end
        checks++;
        if (bus.acc_out !== 64'd0) begin
            errors++;
            $display("FAIL reset_acc: got %h required 0", bus.acc_out);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int lat;
        logic [63:0] res;
        logic b_s, d_s;
        logic seen_done;
        @(negedge clock);
        bus.mor_in = {32'd7, 32'd6};
        bus.start  = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.acc_out !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_op: got busy=%b acc=%h required busy=0 acc=0", bus.busy, bus.acc_out);
        end
        @(negedge clock);
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: got done=1 after reset required no done");
        end
        run_op(32'd6, 32'd7, 1'b0, 1'b0, lat, res, b_s, d_s);
        checks++;
        if (lat !== 33 || res !== 64'd42) begin
            errors++;
            $display("FAIL reset_fresh_op: got lat=%0d acc=%h required lat=33 acc=2a", lat, res);
        end
    endtask

    task automatic test_unsigned_back_to_back();
        int lat;
        logic [63:0] res;
        logic b_s, d_s;
        do_clear();
        run_op(32'd5, 32'd3, 1'b0, 1'b0, lat, res, b_s, d_s);
        checks++;
        if (lat !== 33 || res !== 64'd15) begin
            errors++;
            $display("FAIL unsigned_first: got lat=%0d acc=%h required lat=33 acc=f", lat, res);
        end
        checks++;
        if (b_s !== 1'b1) begin
            errors++;
            $display("FAIL busy_on_start: got busy=%b required 1", b_s);
        end
        run_op(32'd5, 32'd3, 1'b0, 1'b0, lat, res, b_s, d_s);
        checks++;
        if (lat !== 33 || res !== 64'd30) begin
            errors++;
            $display("FAIL unsigned_back_to_back: got lat=%0d acc=%h required lat=33 acc=1e", lat, res);
        end
        checks++;
        if (b_s !== 1'b1 || d_s !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: got busy=%b done=%b after b2b start required busy=1 done=0", b_s, d_s);
        end
        @(posedge clock);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done: got done=%b busy=%b required 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_signed();
        int lat;
        logic [63:0] res;
        logic b_s, d_s;
        do_clear();
        run_op(32'd4, 32'hFFFF_FFFF, 1'b1, 1'b0, lat, res, b_s, d_s);
        checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("FAIL signed_neg: got %h required fffffffffffffffc", res);
        end
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, lat, res, b_s, d_s);
        checks++;
        if (res !== 64'h3FFF_FFFF_FFFF_FFFC || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL signed_min_sq: got acc=%h ovf=%b required 3ffffffffffffffc ovf=0", res, bus.overflow);
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        logic seen_done;
        do_clear();
        @(negedge clock);
        bus.mor_in = {32'd3, 32'd5};
        bus.start  = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        bus.mor_in = {32'd100, 32'd100};
        bus.start  = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(posedge clock);
            #1;
            lat++;
        end
        checks++;
        if (bus.done !== 1'b1 || bus.acc_out !== 64'd15) begin
            errors++;
            $display("FAIL start_while_busy: got done=%b acc=%h required done=1 acc=f", bus.done, bus.acc_out);
        end
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0 || bus.acc_out !== 64'd15) begin
            errors++;
            $display("FAIL no_queued_op: got extra_done=%b acc=%h required 0 acc=f", seen_done, bus.acc_out);
        end
    endtask

    task automatic test_clear_acc();
        int lat;
        logic [63:0] res;
        logic b_s, d_s;
        do_clear();
        run_op(32'd10, 32'd10, 1'b0, 1'b0, lat, res, b_s, d_s);
        checks++;
        if (res !== 64'd100) begin
            errors++;
            $display("FAIL preload_100: got %h required 64", res);
        end
        run_op(32'd9, 32'd2, 1'b0, 1'b1, lat, res, b_s, d_s);
        checks++;
        if (res !== 64'd18 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_with_start: got acc=%h ovf=%b required 12 ovf=0", res, bus.overflow);
        end
        @(negedge clock);
        bus.mor_in = {32'd1, 32'd1};
        bus.start  = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        bus.start     = 1'b0;
        bus.clear_acc = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        bus.clear_acc = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(posedge clock);
            #1;
            lat++;
        end
        checks++;
        if (bus.done !== 1'b1 || bus.acc_out !== 64'd19) begin
            errors++;
            $display("FAIL clear_ignored_busy: got done=%b acc=%h required done=1 acc=13", bus.done, bus.acc_out);
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic [63:0] res;
        logic b_s, d_s;
        logic [63:0] exp_wrap;
        do_clear();
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, lat, res, b_s, d_s);
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, lat, res, b_s, d_s);
        run_op(32'd2, 32'h7FFF_FFFF, 1'b1, 1'b0, lat, res, b_s, d_s);
        checks++;
        if (res !== 64'h7FFF_FFFF_FFFF_FFFF || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL preload_max: got acc=%h ovf=%b required 7fffffffffffffff ovf=0", res, bus.overflow);
        end
        run_op(32'd1, 32'd1, 1'b1, 1'b0, lat, res, b_s, d_s);
`ifdef MAC_SATURATE_EN
        exp_wrap = 64'h7FFF_FFFF_FFFF_FFFF;
`else
        exp_wrap = 64'h8000_0000_0000_0000;
`endif
        checks++;
        if (res !== exp_wrap || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL signed_overflow: got acc=%h ovf=%b required %h ovf=1", res, bus.overflow, exp_wrap);
        end
        run_op(32'd0, 32'd0, 1'b0, 1'b0, lat, res, b_s, d_s);
        checks++;
        if (lat !== 33 || res !== exp_wrap || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL zero_op_sticky: got lat=%0d acc=%h ovf=%b required lat=33 acc=%h ovf=1", lat, res, bus.overflow, exp_wrap);
        end
        do_clear();
        checks++;
        if (bus.overflow !== 1'b0 || bus.acc_out !== 64'd0) begin
            errors++;
            $display("FAIL clear_overflow: got acc=%h ovf=%b required 0 ovf=0", bus.acc_out, bus.overflow);
        end
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, res, b_s, d_s);
        checks++;
        if (res !== 64'hFFFF_FFFE_0000_0001 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL unsigned_max_sq: got acc=%h ovf=%b required fffffffe00000001 ovf=0", res, bus.overflow);
        end
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, res, b_s, d_s);
`ifdef MAC_SATURATE_EN
        exp_wrap = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        exp_wrap = 64'hFFFF_FFFC_0000_0002;
`endif
        checks++;
        if (res !== exp_wrap || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL unsigned_carry: got acc=%h ovf=%b required %h ovf=1", res, bus.overflow, exp_wrap);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_op();
        test_unsigned_back_to_back();
        test_signed();
        test_start_while_busy();
        test_clear_acc();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
